// File: rtl/lut_v_arbiter.sv
// lut_v_arbiter: round-robin two-lane arbiter sharing one combinational V table, with per-lane response slots.
// Optional LUT_V_ARB_STATS_EN adds a saturating 16-bit count of cycles where both lanes are eligible.
module lut_v_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef LUT_V_ARB_STATS_EN
  output logic [15:0]             conflict_cnt,
`endif
  input  logic                    req_valid_0,
  input  logic                    req_valid_1,
  output logic                    req_ready_0,
  output logic                    req_ready_1,
  input  logic [ADDR_WIDTH/2-1:0] req_nsyms_0,
  input  logic [ADDR_WIDTH/2-1:0] req_nsyms_1,
  input  logic [ADDR_WIDTH/2-1:0] req_symbol_0,
  input  logic [ADDR_WIDTH/2-1:0] req_symbol_1,
  output logic                    rsp_valid_0,
  output logic                    rsp_valid_1,
  input  logic                    rsp_ready_0,
  input  logic                    rsp_ready_1,
  output logic [DATA_WIDTH-1:0]   rsp_v_0,
  output logic [DATA_WIDTH-1:0]   rsp_v_1,
  output logic                    rsp_err_0,
  output logic                    rsp_err_1,
  output logic [ADDR_WIDTH-1:0]   lut_addr,
  input  logic [DATA_WIDTH-1:0]   lut_q
);
  logic elig_0, elig_1, prio;
  always_comb begin
    elig_0 = req_valid_0 & (~rsp_valid_0 | rsp_ready_0);
    elig_1 = req_valid_1 & (~rsp_valid_1 | rsp_ready_1);
    req_ready_0 = ~reset & elig_0 & (~elig_1 | ~prio);
    req_ready_1 = ~reset & elig_1 & (~elig_0 | prio);
    lut_addr = req_ready_0 ? {req_nsyms_0, req_symbol_0} :
               req_ready_1 ? {req_nsyms_1, req_symbol_1} : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_v_0 <= '0;
      rsp_v_1 <= '0;
      rsp_err_0 <= 1'b0;
      rsp_err_1 <= 1'b0;
    end else begin
      prio <= req_ready_0 ? 1'b1 : req_ready_1 ? 1'b0 : prio;
      if (req_ready_0) begin
        rsp_v_0 <= lut_q;
        rsp_err_0 <= req_symbol_0 >= req_nsyms_0;
        rsp_valid_0 <= 1'b1;
      end else if (rsp_ready_0) rsp_valid_0 <= 1'b0;
      if (req_ready_1) begin
        rsp_v_1 <= lut_q;
        rsp_err_1 <= req_symbol_1 >= req_nsyms_1;
        rsp_valid_1 <= 1'b1;
      end else if (rsp_ready_1) rsp_valid_1 <= 1'b0;
    end
  end
`ifdef LUT_V_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) conflict_cnt <= '0;
    else if (elig_0 & elig_1 & (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_lut_v_arbiter.sv
// tb_lut_v_arbiter: directed bench with per-lane response scoreboards for lut_v_arbiter.
module tb_lut_v_arbiter;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int HW = AW / 2;
  typedef struct packed {logic [DW-1:0] v; logic err;} rsp_t;
  logic clk = 1'b0;
  logic reset;
  logic req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [HW-1:0] n0, n1, s0, s1;
  logic rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
  logic [DW-1:0] rsp_v_0, rsp_v_1;
  logic rsp_err_0, rsp_err_1;
  logic [AW-1:0] lut_addr;
  logic [DW-1:0] lut_q;
`ifdef LUT_V_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif
  rsp_t q0[$], q1[$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  lut_v_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
`ifdef LUT_V_ARB_STATS_EN
    .conflict_cnt(conflict_cnt),
`endif
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_nsyms_0(n0), .req_nsyms_1(n1),
    .req_symbol_0(s0), .req_symbol_1(s1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_v_0(rsp_v_0), .rsp_v_1(rsp_v_1),
    .rsp_err_0(rsp_err_0), .rsp_err_1(rsp_err_1),
    .lut_addr(lut_addr), .lut_q(lut_q)
  );
  // Table stub: V = 4*(N-s) for valid symbols, 0 for out-of-range addresses.
  function automatic logic [DW-1:0] vmodel(logic [HW-1:0] n, logic [HW-1:0] s);
    return (s < n) ? DW'(4 * (int'(n) - int'(s))) : '0;
  endfunction
  always_comb lut_q = vmodel(lut_addr[AW-1:HW], lut_addr[HW-1:0]);
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic sb();
    rsp_t e;
    if (rsp_valid_0 && rsp_ready_0) begin
      chk("sb0_nonempty", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("sb0_v", 32'(rsp_v_0), 32'(e.v));
        chk("sb0_err", 32'(rsp_err_0), 32'(e.err));
      end
    end
    if (rsp_valid_1 && rsp_ready_1) begin
      chk("sb1_nonempty", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("sb1_v", 32'(rsp_v_1), 32'(e.v));
        chk("sb1_err", 32'(rsp_err_1), 32'(e.err));
      end
    end
    if (req_ready_0) begin
      e.v = vmodel(n0, s0);
      e.err = s0 >= n0;
      q0.push_back(e);
    end
    if (req_ready_1) begin
      e.v = vmodel(n1, s1);
      e.err = s1 >= n1;
      q1.push_back(e);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    sb();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    {req_valid_0, req_valid_1, n0, n1, s0, s1} = '0;
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid_0", 32'(rsp_valid_0), 0);
    chk("rst_rsp_valid_1", 32'(rsp_valid_1), 0);
    chk("rst_rsp_v_0", 32'(rsp_v_0), 0);
    chk("rst_rsp_err_1", 32'(rsp_err_1), 0);
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    #1;
    chk("rst_ready_0", 32'(req_ready_0), 0);
    chk("rst_ready_1", 32'(req_ready_1), 0);
    chk("rst_lut_addr", 32'(lut_addr), 0);
    {req_valid_0, req_valid_1} = '0;
    reset = 1'b0;
    // single lane basic lookup
    req_valid_0 = 1'b1; n0 = 4'd5; s0 = 4'd1;
    #1;
    chk("basic_ready_0", 32'(req_ready_0), 1);
    chk("basic_ready_1", 32'(req_ready_1), 0);
    chk("basic_addr", 32'(lut_addr), 81);
    tick();
    req_valid_0 = 1'b0;
    #1;
    chk("basic_rsp_valid", 32'(rsp_valid_0), 1);
    chk("basic_rsp_v", 32'(rsp_v_0), 16);
    chk("basic_rsp_err", 32'(rsp_err_0), 0);
    chk("idle_addr", 32'(lut_addr), 0);
    tick();
    chk("basic_drained", 32'(rsp_valid_0), 0);
    // simultaneous requests, alternating from lane 0 after reset
    pulse_reset();
    req_valid_0 = 1'b1; n0 = 4'd3; s0 = 4'd0;
    req_valid_1 = 1'b1; n1 = 4'd15; s1 = 4'd0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("alt_ready_0", 32'(req_ready_0), 32'(i % 2 == 0));
      chk("alt_ready_1", 32'(req_ready_1), 32'(i % 2 == 1));
      chk("alt_addr", 32'(lut_addr), (i % 2 == 0) ? 32'h30 : 32'hF0);
`ifdef LUT_V_ARB_STATS_EN
      chk("alt_conflict", 32'(conflict_cnt), 32'(i));
`endif
      tick();
    end
    chk("alt_rsp_v_0", 32'(rsp_v_0), 12);
    chk("alt_rsp_v_1", 32'(rsp_v_1), 60);
    // error responses on lane 1, plus the s = N-1 boundary
    req_valid_0 = 1'b0;
    n1 = 4'd2; s1 = 4'd2;
    #1;
    chk("err_ready_1", 32'(req_ready_1), 1);
    chk("err_addr", 32'(lut_addr), 32'h22);
    tick();
    chk("err_rsp_v", 32'(rsp_v_1), 0);
    chk("err_rsp_err", 32'(rsp_err_1), 1);
    n1 = 4'd0; s1 = 4'd0;
    tick();
    chk("err_n0", 32'(rsp_err_1), 1);
    n1 = 4'd2; s1 = 4'd1;
    tick();
    chk("edge_err", 32'(rsp_err_1), 0);
    chk("edge_v", 32'(rsp_v_1), 4);
    req_valid_1 = 1'b0;
    tick();
    // backpressure on lane 0
    rsp_ready_0 = 1'b0;
    req_valid_0 = 1'b1; n0 = 4'd7; s0 = 4'd2;
    tick();
    n0 = 4'd4; s0 = 4'd1;
    req_valid_1 = 1'b1; n1 = 4'd9;
    for (int k = 0; k < 4; k++) begin
      s1 = 4'(k);
      #1;
      chk("bp_ready_0", 32'(req_ready_0), 0);
      chk("bp_ready_1", 32'(req_ready_1), 1);
      chk("bp_hold_v_0", 32'(rsp_v_0), 20);
      tick();
    end
    rsp_ready_0 = 1'b1;
    #1;
    chk("bp_release_ready_0", 32'(req_ready_0), 1);
    chk("bp_release_ready_1", 32'(req_ready_1), 0);
    tick();
    chk("bp_reload_valid", 32'(rsp_valid_0), 1);
    chk("bp_reload_v", 32'(rsp_v_0), 12);
    // asynchronous reset with both slots full
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    repeat (3) tick();
    chk("full_valid_0", 32'(rsp_valid_0), 1);
    chk("full_valid_1", 32'(rsp_valid_1), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_valid_0", 32'(rsp_valid_0), 0);
    chk("async_valid_1", 32'(rsp_valid_1), 0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    #1;
    chk("post_rst_ready_0", 32'(req_ready_0), 1);
    chk("post_rst_ready_1", 32'(req_ready_1), 0);
    tick();
    chk("post_rst_second_1", 32'(req_ready_1), 1);
`ifdef LUT_V_ARB_STATS_EN
    pulse_reset();
    repeat (65540) @(posedge clk);
    #1;
    chk("conflict_sat", 32'(conflict_cnt), 32'hFFFF);
    pulse_reset();
`endif
    {req_valid_0, req_valid_1} = '0;
    repeat (3) tick();
    chk("q0_empty", 32'(q0.size()), 0);
    chk("q1_empty", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
